// File: rtl/handshake_rx.sv
// handshake_rx: destination end of a 4-phase req/ack handshake.
// The req_in level is synchronized into clk, data_in is captured once per
// request and offered as a single beat on the rd_stream master, and a
// registered ack_out level is returned to the source.
// Optional build macro: HANDSHAKE_RX_ERR_EN adds a sticky o_err flag that
// records req_sync falling while a beat is still pending.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for req_sync high; captures data_in on the way out
// S_VALID | beat offered on rd_stream, held until valid & ready
// S_ACK   | ack_out held high until req_sync returns low
module handshake_rx #(
  parameter int BITWIDTH    = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_req_in,
  input  logic [BITWIDTH-1:0] i_data_in,
  output logic                o_ack_out,
  output logic                o_rd_stream_valid,
  input  logic                i_rd_stream_ready,
  output logic [BITWIDTH-1:0] o_rd_stream_data,
  output logic                o_rd_stream_ok
`ifdef HANDSHAKE_RX_ERR_EN
  ,
  output logic                o_err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_VALID = 2'd1,
    S_ACK   = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_req_sync;
  logic [BITWIDTH-1:0]    r_capture;
  logic                   w_capture_en;
  logic                   r_ack;
  logic                   w_valid;
  logic                   w_ok;

  assign w_req_sync = r_sync[SYNC_STAGES-1];

  // Synchronizer chain for the asynchronous request level.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_req_in};
    end
  end

  // State register, capture register and registered acknowledge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_capture <= '0;
      r_ack     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      // ack is high exactly while the FSM sits in S_ACK
      r_ack   <= (w_state_next == S_ACK);
      if (w_capture_en) begin
        r_capture <= i_data_in;
      end
    end
  end

  // Next-state decode and stream outputs.
  always_comb begin
    w_state_next = r_state;
    w_capture_en = 1'b0;
    w_valid      = 1'b0;
    w_ok         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req_sync) begin
          w_capture_en = 1'b1;
          w_state_next = S_VALID;
        end
      end
      S_VALID: begin
        w_valid = 1'b1;
        w_ok    = i_rd_stream_ready;
        if (i_rd_stream_ready) begin
          w_state_next = S_ACK;
        end
      end
      S_ACK: begin
        if (!w_req_sync) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign o_ack_out         = r_ack;
  assign o_rd_stream_valid = w_valid;
  assign o_rd_stream_ok    = w_ok;
  // data is forced to zero whenever no beat is being offered
  assign o_rd_stream_data  = w_valid ? r_capture : '0;

`ifdef HANDSHAKE_RX_ERR_EN
  logic r_err;

  // Sticky flag: source withdrew its request before the beat was taken.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_err <= 1'b0;
    end else if ((r_state == S_VALID) && !w_req_sync) begin
      r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
`endif

endmodule

// File: tb/tb_handshake_rx.sv
// Testbench for handshake_rx (BITWIDTH=8, SYNC_STAGES=2): a per-edge vector
// table for single-beat and backpressure transfers, followed by hand-written
// sequences for back-to-back transfers, held request, reset and error flag.
module tb_handshake_rx;

  localparam int W = 8;
  localparam int N = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_in;
  logic [W-1:0] data_in;
  logic         ack_out;
  logic         valid;
  logic         ready;
  logic [W-1:0] data_out;
  logic         ok;
`ifdef HANDSHAKE_RX_ERR_EN
  logic         err;
`endif

  int checks = 0;
  int errors = 0;

  handshake_rx #(.BITWIDTH(W), .SYNC_STAGES(N)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_req_in         (req_in),
    .i_data_in        (data_in),
    .o_ack_out        (ack_out),
    .o_rd_stream_valid(valid),
    .i_rd_stream_ready(ready),
    .o_rd_stream_data (data_out),
    .o_rd_stream_ok   (ok)
`ifdef HANDSHAKE_RX_ERR_EN
    ,
    .o_err            (err)
`endif
  );

  always #5 clk = ~clk;

  // One row: inputs applied before an edge, outputs expected after it.
  typedef struct {
    logic         req;
    logic [W-1:0] data;
    logic         rdy;
    logic         exp_valid;
    logic [W-1:0] exp_data;
    logic         exp_ack;
  } vec_t;

  vec_t vq[$];

  logic         mon_en = 1'b0;
  logic [W-1:0] beats[$];

  // Collect accepted beats mid-cycle (ready is constant while enabled).
  always @(negedge clk) begin
    if (mon_en && valid && ready) beats.push_back(data_out);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_ack(input logic lvl, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack_out === lvl) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, {31'd0, seen}, 32'd1);
  endtask

  task automatic wait_valid(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, {31'd0, seen}, 32'd1);
  endtask

  task automatic transfer(input logic [W-1:0] d);
    data_in = d;
    req_in  = 1'b1;
    wait_ack(1'b1, "b2b_ack_rise");
    req_in  = 1'b0;
    wait_ack(1'b0, "b2b_ack_fall");
  endtask

  initial begin
    // single beat, ready=1: capture at edge 3, ok at edge 4, req low at
    // edge 6 -> ack low after edge 8
    vq.push_back('{1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0}); // e1
    vq.push_back('{1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0}); // e2
    vq.push_back('{1'b1, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0}); // e3 valid
    vq.push_back('{1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b1}); // e4 ok -> ack
    vq.push_back('{1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b1}); // e5
    vq.push_back('{1'b0, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b1}); // e6 req low
    vq.push_back('{1'b0, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b1}); // e7
    vq.push_back('{1'b0, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0}); // e8 ack low
    vq.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0}); // e9 idle
    // backpressure: ready=0 for five valid cycles, then one ok
    vq.push_back('{1'b1, 8'h3C, 1'b0, 1'b0, 8'h00, 1'b0});
    vq.push_back('{1'b1, 8'h3C, 1'b0, 1'b0, 8'h00, 1'b0});
    vq.push_back('{1'b1, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0});
    vq.push_back('{1'b1, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0});
    vq.push_back('{1'b1, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0});
    vq.push_back('{1'b1, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0});
    vq.push_back('{1'b1, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0});
    vq.push_back('{1'b1, 8'h3C, 1'b1, 1'b0, 8'h00, 1'b1}); // ok
    vq.push_back('{1'b0, 8'h3C, 1'b1, 1'b0, 8'h00, 1'b1});
    vq.push_back('{1'b0, 8'h3C, 1'b1, 1'b0, 8'h00, 1'b1});
    vq.push_back('{1'b0, 8'h3C, 1'b1, 1'b0, 8'h00, 1'b0});

    rst = 1'b1; req_in = 1'b0; data_in = '0; ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_ack", {31'd0, ack_out}, 32'd0);
    check("reset_data", {24'd0, data_out}, 32'd0);
    rst = 1'b0;

    foreach (vq[i]) begin
      req_in  = vq[i].req;
      data_in = vq[i].data;
      ready   = vq[i].rdy;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), {31'd0, valid}, {31'd0, vq[i].exp_valid});
      check($sformatf("vec%0d_data", i), {24'd0, data_out}, {24'd0, vq[i].exp_data});
      check($sformatf("vec%0d_ack", i), {31'd0, ack_out}, {31'd0, vq[i].exp_ack});
    end

    // back-to-back transfers driven by a source that honours ack_out
    ready = 1'b1;
    beats.delete();
    mon_en = 1'b1;
    for (int k = 1; k <= 4; k++) transfer(W'(k));
    repeat (4) @(negedge clk);
    mon_en = 1'b0;
    check("b2b_count", beats.size(), 32'd4);
    for (int k = 0; k < 4 && k < beats.size(); k++)
      check($sformatf("b2b_beat%0d", k), {24'd0, beats[k]}, k + 1);

    // request held high after ack: no re-capture
    beats.delete();
    mon_en = 1'b1;
    data_in = 8'h5A;
    req_in  = 1'b1;
    wait_ack(1'b1, "hold_ack_rise");
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("hold_valid%0d", k), {31'd0, valid}, 32'd0);
      check($sformatf("hold_ack%0d", k), {31'd0, ack_out}, 32'd1);
    end
    mon_en = 1'b0;
    check("hold_beats", beats.size(), 32'd1);
    req_in = 1'b0;
    wait_ack(1'b0, "hold_ack_fall");

    // reset mid-VALID, then release with request still high
    ready   = 1'b0;
    data_in = 8'h55;
    req_in  = 1'b1;
    wait_valid("rst_pre_valid");
    #2 rst = 1'b1;
    #1;
    check("rst_async_valid", {31'd0, valid}, 32'd0);
    check("rst_async_ack", {31'd0, ack_out}, 32'd0);
    @(negedge clk);
    data_in = 8'h77;
    rst = 1'b0;
    for (int k = 1; k <= N + 1; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("rst_rel_valid_e%0d", k), {31'd0, valid}, {31'd0, (k == N + 1)});
    end
    check("rst_rel_data", {24'd0, data_out}, 32'h77);
    ready = 1'b1;
    wait_ack(1'b1, "rst_rel_ack_rise");
    req_in = 1'b0;
    wait_ack(1'b0, "rst_rel_ack_fall");

`ifdef HANDSHAKE_RX_ERR_EN
    // request withdrawn while the beat is pending
    ready   = 1'b0;
    data_in = 8'h99;
    req_in  = 1'b1;
    wait_valid("err_pre_valid");
    check("err_clear_before", {31'd0, err}, 32'd0);
    req_in = 1'b0;
    repeat (4) @(negedge clk);
    check("err_set", {31'd0, err}, 32'd1);
    check("err_valid_held", {31'd0, valid}, 32'd1);
    check("err_data_held", {24'd0, data_out}, 32'h99);
    ready = 1'b1;
    @(negedge clk);
    check("err_ack_pulse", {31'd0, ack_out}, 32'd1);
    check("err_valid_done", {31'd0, valid}, 32'd0);
    @(negedge clk);
    check("err_ack_pulse_end", {31'd0, ack_out}, 32'd0);
    repeat (3) @(negedge clk);
    check("err_sticky", {31'd0, err}, 32'd1);
    rst = 1'b1;
    #1;
    check("err_rst_clear", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
